// File: rtl/uart_mem_dump_if.sv
// uart_mem_dump_if: rib master port bundle for the memory dump UART.
// Ports: req_o/mem_we_o/mem_addr_o/mem_wdata_o travel master->slave.
//        mem_rdata_i/grant_i travel slave->master.
interface uart_mem_dump_if;
  logic        req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        grant_i;

  modport master (
    output req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, grant_i
  );

  modport slave (
    input  req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, grant_i
  );
endinterface

// File: rtl/uart_mem_dump.sv
// Purpose: read word_cnt 32-bit words over rib and send each one as four 8N1 UART bytes, LSB first.
// Latency: start -> REQ 1 cycle; grant -> start bit 1 cycle; each byte takes exactly 10*BAUD_DIV clocks.
// Backpressure: REQ holds req_o/mem_addr_o stable for as long as grant_i stays low; abort_i ends the dump cleanly.
//
// Ports: clk, rst (async, active low); start_i/base_addr_i/word_cnt_i launch a dump;
//        abort_i stops it; busy_o/done_o report status; bus is the rib master port; tx_pin is the UART line.
// Build option: define DUMP_CKSUM_EN to append an 8-bit sum of all data bytes after the last word.
module uart_mem_dump #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [31:0]     base_addr_i,
  input  logic [15:0]     word_cnt_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            done_o,
  uart_mem_dump_if.master bus,
  output logic            tx_pin
);
  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    SEND  = 3'd2,
    NEXT  = 3'd3,
`ifdef DUMP_CKSUM_EN
    CKSUM = 3'd4,
`endif
    FIN   = 3'd5
  } state_t;

  // State entered once the word list is exhausted (or empty).
`ifdef DUMP_CKSUM_EN
  localparam state_t LAST_ST = CKSUM;
`else
  localparam state_t LAST_ST = FIN;
`endif

  state_t        state, state_nxt;
  logic [31:0]   addr;
  logic [31:0]   word;
  logic [15:0]   remain;
  logic [1:0]    byte_idx;
  logic [3:0]    bit_idx;
  logic [CW-1:0] baud_cnt;
  logic          abort_pend;
  logic          req, tx, busy, done;
  logic [7:0]    cur_byte;
  logic [15:0]   frame;
  logic          in_frame, nxt_frame;
  logic          bit_end, byte_end, frame_start;
`ifdef DUMP_CKSUM_EN
  logic [7:0]    cksum;
`endif

  assign bus.req_o       = req;
  assign bus.mem_addr_o  = addr;
  assign bus.mem_we_o    = 1'b0;
  assign bus.mem_wdata_o = 32'd0;
  assign busy_o          = busy;
  assign done_o          = done;
  assign tx_pin          = tx;

  always_comb begin
    cur_byte  = word[{byte_idx, 3'b000} +: 8];
    in_frame  = (state == SEND);
    nxt_frame = (state_nxt == SEND);
`ifdef DUMP_CKSUM_EN
    if (state == CKSUM) cur_byte = cksum;
    in_frame  = in_frame  || (state == CKSUM);
    nxt_frame = nxt_frame || (state_nxt == CKSUM);
`endif
  end

  // Frame bits 0..9 are start, data LSB first, stop; the ones above keep the
  // line high when bit_idx steps past the stop bit.
  assign frame       = {6'h3F, 1'b1, cur_byte, 1'b0};
  assign bit_end     = (baud_cnt == CW'(BAUD_DIV - 1));
  assign byte_end    = in_frame && bit_end && (bit_idx == 4'd9);
  // A new start bit goes out when a frame is entered or a byte rolls straight into the next.
  assign frame_start = nxt_frame && (!in_frame || byte_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i) state_nxt = (word_cnt_i == 16'd0) ? LAST_ST : REQ;
      REQ: begin
        if (abort_i)          state_nxt = IDLE;
        else if (bus.grant_i) state_nxt = SEND;
      end
      SEND: begin
        if (byte_end) begin
          if (abort_pend || abort_i) state_nxt = IDLE;
          else if (byte_idx == 2'd3) state_nxt = NEXT;
        end
      end
      NEXT: state_nxt = (remain == 16'd1) ? LAST_ST : REQ;
`ifdef DUMP_CKSUM_EN
      CKSUM: if (byte_end) state_nxt = (abort_pend || abort_i) ? IDLE : FIN;
`endif
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus side and status; req/busy are registered copies of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr       <= 32'd0;
      remain     <= 16'd0;
      word       <= 32'd0;
      byte_idx   <= 2'd0;
      abort_pend <= 1'b0;
    end else begin
      req  <= (state_nxt == REQ);
      busy <= (state_nxt != IDLE);
      done <= (state == FIN);
      if (state == IDLE && start_i) begin
        addr   <= {base_addr_i[31:2], 2'b00};
        remain <= word_cnt_i;
      end else if (state == NEXT) begin
        addr   <= addr + 32'd4;
        remain <= remain - 16'd1;
      end
      if (state == REQ && bus.grant_i) begin
        word     <= bus.mem_rdata_i;
        byte_idx <= 2'd0;
      end else if (state == SEND && byte_end) begin
        byte_idx <= byte_idx + 2'd1;
      end
      // A short abort pulse during a byte must still end the dump at its stop bit.
      if (state == IDLE)              abort_pend <= 1'b0;
      else if (in_frame && abort_i)   abort_pend <= 1'b1;
    end
  end

  // Bit timer and serialiser; tx idles high and reset forces it high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
    end else if (frame_start) begin
      tx       <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
    end else if (in_frame) begin
      if (bit_end) begin
        baud_cnt <= '0;
        bit_idx  <= bit_idx + 4'd1;
        tx       <= frame[bit_idx + 4'd1];
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end else begin
      tx <= 1'b1;
    end
  end

`ifdef DUMP_CKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          cksum <= 8'd0;
    else if (state == IDLE && start_i) cksum <= 8'd0;
    else if (state == SEND && byte_end) cksum <= cksum + cur_byte;
  end
`endif
endmodule

// File: tb/tb_uart_mem_dump.sv
module tb_uart_mem_dump;
`ifdef DUMP_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base = 32'd0;
  logic [15:0] cnt = 16'd0;
  logic        abort = 1'b0;
  logic        busy, done, tx;
  logic        gnt_en = 1'b1;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0]  rx_q[$];
  int          rx_st_q[$];
  int          rx_ferr = 0;
  logic [31:0] g_addr_q[$];
  int          g_cyc_q[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          r0, g0, d0, f0;

  uart_mem_dump_if bus();

  uart_mem_dump #(.CLK_HZ(8), .BAUD(2)) dut (
    .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base), .word_cnt_i(cnt),
    .abort_i(abort), .busy_o(busy), .done_o(done), .bus(bus), .tx_pin(tx)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h10000000: mem_rd = 32'hA55A1234;
      32'h10000004: mem_rd = 32'h0BADF00D;
      32'h10000008: mem_rd = 32'hC0FFEE11;
      32'hFFFFFFFC: mem_rd = 32'h11223344;
      32'h00000000: mem_rd = 32'h55667788;
      32'h20000000: mem_rd = 32'h01020304;
      default:      mem_rd = 32'h0;
    endcase
  endfunction

  assign bus.grant_i     = bus.req_o & gnt_en;
  assign bus.mem_rdata_i = bus.grant_i ? mem_rd(bus.mem_addr_o) : 32'hDEADBEEF;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.req_o === 1'b1 && bus.grant_i === 1'b1) begin
      g_addr_q.push_back(bus.mem_addr_o);
      g_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // UART receiver: samples the middle (clock 2 of 4) of each bit.
  initial begin
    logic [7:0] b;
    bit ok;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        rx_st_q.push_back(cyc);
        ok = 1'b1;
        b  = 8'h00;
        repeat (2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge clk);
          b[k] = tx;
        end
        repeat (4) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        rx_q.push_back(b);
        if (!ok) rx_ferr = rx_ferr + 1;
      end
    end
  end

  function automatic logic [7:0] q_byte(input int i);
    q_byte = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction
  function automatic int q_st(input int i);
    q_st = (i < rx_st_q.size()) ? rx_st_q[i] : -1;
  endfunction
  function automatic logic [31:0] q_gaddr(input int i);
    q_gaddr = (i < g_addr_q.size()) ? g_addr_q[i] : 32'hxxxxxxxx;
  endfunction
  function automatic int q_gcyc(input int i);
    q_gcyc = (i < g_cyc_q.size()) ? g_cyc_q[i] : -1;
  endfunction

  task automatic snap();
    r0 = rx_q.size();
    g0 = g_addr_q.size();
    d0 = done_cnt;
    f0 = rx_ferr;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] n, output int c0);
    @(posedge clk); #1;
    base = b; cnt = n; start = 1'b1; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt > d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
    n_checks++; if (bus.req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.req_o); end
    n_checks++; if (bus.mem_addr_o !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", bus.mem_addr_o); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_status got busy=%b done=%b want 0 0", busy, done); end
    n_checks++; if (bus.mem_we_o !== 1'b0 || bus.mem_wdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_we got we=%b wdata=%h want 0", bus.mem_we_o, bus.mem_wdata_o); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_single();
    int c0; bit ok; bit sp;
    logic [7:0] exp_b [4];
    exp_b = '{8'h34, 8'h12, 8'h5A, 8'hA5};
    snap(); gnt_en = 1'b1;
    pulse_start(32'h10000000, 16'd1, c0);
    n_checks++; if (busy !== 1'b1 || bus.req_o !== 1'b1) begin n_fail++; $display("FAIL single_launch got busy=%b req=%b want 1 1", busy, bus.req_o); end
    n_checks++; if (bus.mem_addr_o !== 32'h10000000) begin n_fail++; $display("FAIL single_addr got %h want 10000000", bus.mem_addr_o); end
    wait_done(400, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_done_timeout got no done want done"); end
    repeat (4) @(posedge clk); #1;
    n_checks++; if (rx_q.size() - r0 !== 4 + CK) begin n_fail++; $display("FAIL single_nbytes got %0d want %0d", rx_q.size() - r0, 4 + CK); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (q_byte(r0 + i) !== exp_b[i]) begin n_fail++; $display("FAIL single_byte%0d got %h want %h", i, q_byte(r0 + i), exp_b[i]); end
    end
`ifdef DUMP_CKSUM_EN
    n_checks++; if (q_byte(r0 + 4) !== 8'h45) begin n_fail++; $display("FAIL single_cksum got %h want 45", q_byte(r0 + 4)); end
`endif
    n_checks++; if (q_gcyc(g0) !== c0 + 1 || q_st(r0) !== c0 + 2) begin n_fail++; $display("FAIL single_latency got grant@%0d start@%0d want %0d %0d", q_gcyc(g0), q_st(r0), c0 + 1, c0 + 2); end
    sp = 1'b1;
    for (int i = 0; i < 3; i++) if (q_st(r0 + i + 1) - q_st(r0 + i) != 40) sp = 1'b0;
    n_checks++; if (sp !== 1'b1) begin n_fail++; $display("FAIL single_byte_time got %0d want 40", q_st(r0 + 1) - q_st(r0)); end
    n_checks++; if (g_addr_q.size() - g0 !== 1 || q_gaddr(g0) !== 32'h10000000) begin n_fail++; $display("FAIL single_grants got n=%0d a=%h want 1 10000000", g_addr_q.size() - g0, q_gaddr(g0)); end
    n_checks++; if (done_cnt - d0 !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_finish got done=%0d busy=%b want 1 0", done_cnt - d0, busy); end
    n_checks++; if (rx_ferr !== f0) begin n_fail++; $display("FAIL single_framing got %0d want %0d", rx_ferr, f0); end
  endtask

  task automatic test_multi();
    int c0; bit ok;
    snap();
    pulse_start(32'h10000002, 16'd3, c0);
    repeat (20) @(posedge clk); #1;
    base = 32'h30000000; cnt = 16'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(800, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL multi_done_timeout got no done want done"); end
    repeat (4) @(posedge clk); #1;
    n_checks++; if (g_addr_q.size() - g0 !== 3) begin n_fail++; $display("FAIL multi_ngrants got %0d want 3", g_addr_q.size() - g0); end
    n_checks++; if (q_gaddr(g0) !== 32'h10000000 || q_gaddr(g0 + 1) !== 32'h10000004 || q_gaddr(g0 + 2) !== 32'h10000008) begin
      n_fail++; $display("FAIL multi_addrs got %h %h %h want 10000000 10000004 10000008", q_gaddr(g0), q_gaddr(g0 + 1), q_gaddr(g0 + 2)); end
    n_checks++; if (rx_q.size() - r0 !== 12 + CK) begin n_fail++; $display("FAIL multi_nbytes got %0d want %0d", rx_q.size() - r0, 12 + CK); end
    n_checks++; if (q_byte(r0 + 4) !== 8'h0D || q_byte(r0 + 11) !== 8'hC0) begin n_fail++; $display("FAIL multi_bytes got %h %h want 0d c0", q_byte(r0 + 4), q_byte(r0 + 11)); end
    n_checks++; if (q_st(r0 + 4) - q_st(r0 + 3) !== 42) begin n_fail++; $display("FAIL multi_word_gap got %0d want 42", q_st(r0 + 4) - q_st(r0 + 3)); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL multi_ndone got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_grant_wait();
    int c0; int gc; bit ok; bit stable;
    snap(); gnt_en = 1'b0;
    pulse_start(32'h10000004, 16'd1, c0);
    stable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (bus.req_o !== 1'b1 || bus.mem_addr_o !== 32'h10000004 || tx !== 1'b1) stable = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL wait_stable got unstable req/addr/tx want stable"); end
    gnt_en = 1'b1; gc = cyc;
    wait_done(400, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wait_done_timeout got no done want done"); end
    repeat (4) @(posedge clk); #1;
    n_checks++; if (g_addr_q.size() - g0 !== 1 || q_gcyc(g0) !== gc) begin n_fail++; $display("FAIL wait_grant got n=%0d at %0d want 1 at %0d", g_addr_q.size() - g0, q_gcyc(g0), gc); end
    n_checks++; if (q_byte(r0) !== 8'h0D || q_byte(r0 + 1) !== 8'hF0 || q_byte(r0 + 2) !== 8'hAD || q_byte(r0 + 3) !== 8'h0B) begin
      n_fail++; $display("FAIL wait_data got %h %h %h %h want 0d f0 ad 0b", q_byte(r0), q_byte(r0 + 1), q_byte(r0 + 2), q_byte(r0 + 3)); end
    n_checks++; if (q_st(r0) !== gc + 1) begin n_fail++; $display("FAIL wait_start got %0d want %0d", q_st(r0), gc + 1); end
  endtask

  task automatic test_wrap();
    int c0; bit ok;
    snap();
    pulse_start(32'hFFFFFFFC, 16'd2, c0);
    wait_done(600, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_done_timeout got no done want done"); end
    repeat (4) @(posedge clk); #1;
    n_checks++; if (q_gaddr(g0) !== 32'hFFFFFFFC || q_gaddr(g0 + 1) !== 32'h00000000) begin n_fail++; $display("FAIL wrap_addrs got %h %h want fffffffc 00000000", q_gaddr(g0), q_gaddr(g0 + 1)); end
    n_checks++; if (q_byte(r0) !== 8'h44 || q_byte(r0 + 4) !== 8'h88 || q_byte(r0 + 7) !== 8'h55) begin
      n_fail++; $display("FAIL wrap_bytes got %h %h %h want 44 88 55", q_byte(r0), q_byte(r0 + 4), q_byte(r0 + 7)); end
  endtask

  task automatic test_abort_req();
    int c0;
    snap(); gnt_en = 1'b0;
    pulse_start(32'h10000008, 16'd1, c0);
    repeat (2) @(posedge clk); #1;
    n_checks++; if (bus.req_o !== 1'b1) begin n_fail++; $display("FAIL abreq_pre got req=%b want 1", bus.req_o); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++; if (bus.req_o !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abreq_drop got req=%b busy=%b want 0 0", bus.req_o, busy); end
    repeat (10) @(posedge clk); #1;
    gnt_en = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (done_cnt - d0 !== 0 || g_addr_q.size() - g0 !== 0 || bus.req_o !== 1'b0) begin
      n_fail++; $display("FAIL abreq_quiet got done=%0d grants=%0d req=%b want 0 0 0", done_cnt - d0, g_addr_q.size() - g0, bus.req_o); end
  endtask

  task automatic test_abort_send();
    int c0; bit seen;
    snap(); gnt_en = 1'b1;
    pulse_start(32'h10000000, 16'd3, c0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (rx_st_q.size() >= r0 + 2) begin seen = 1'b1; break; end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL absend_timeout got no byte1 want byte1"); end
    repeat (5) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (80) @(posedge clk); #1;
    n_checks++; if (rx_q.size() - r0 !== 2 || q_byte(r0 + 1) !== 8'h12) begin n_fail++; $display("FAIL absend_bytes got n=%0d b1=%h want 2 12", rx_q.size() - r0, q_byte(r0 + 1)); end
    n_checks++; if (rx_ferr !== f0) begin n_fail++; $display("FAIL absend_stop got %0d framing errors want 0", rx_ferr - f0); end
    n_checks++; if (g_addr_q.size() - g0 !== 1 || bus.req_o !== 1'b0) begin n_fail++; $display("FAIL absend_req got grants=%0d req=%b want 1 0", g_addr_q.size() - g0, bus.req_o); end
    n_checks++; if (done_cnt - d0 !== 0 || busy !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL absend_state got done=%0d busy=%b tx=%b want 0 0 1", done_cnt - d0, busy, tx); end
  endtask

  task automatic test_zero();
    int c0; bit ok;
    snap();
    pulse_start(32'h10000000, 16'd0, c0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy got %b want 1", busy); end
    wait_done(100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_done_timeout got no done want done"); end
    repeat (4) @(posedge clk); #1;
    n_checks++; if (g_addr_q.size() - g0 !== 0 || rx_q.size() - r0 !== CK) begin n_fail++; $display("FAIL zero_activity got grants=%0d bytes=%0d want 0 %0d", g_addr_q.size() - g0, rx_q.size() - r0, CK); end
`ifdef DUMP_CKSUM_EN
    n_checks++; if (q_byte(r0) !== 8'h00) begin n_fail++; $display("FAIL zero_cksum got %h want 00", q_byte(r0)); end
`else
    n_checks++; if (done_cyc !== c0 + 2) begin n_fail++; $display("FAIL zero_done_time got %0d want %0d", done_cyc, c0 + 2); end
`endif
  endtask

`ifdef DUMP_CKSUM_EN
  task automatic test_cksum();
    int c0; bit ok;
    snap();
    pulse_start(32'h20000000, 16'd1, c0);
    wait_done(400, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cksum_done_timeout got no done want done"); end
    repeat (4) @(posedge clk); #1;
    n_checks++; if (rx_q.size() - r0 !== 5 || q_byte(r0 + 4) !== 8'h0A) begin n_fail++; $display("FAIL cksum_byte got n=%0d b=%h want 5 0a", rx_q.size() - r0, q_byte(r0 + 4)); end
  endtask
`endif

  task automatic test_reset_mid();
    int c0; bit seen;
    snap();
    pulse_start(32'h10000000, 16'd1, c0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (rx_st_q.size() > r0) begin seen = 1'b1; break; end
    end
    n_checks++; if (seen !== 1'b1 || tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre got seen=%b tx=%b want 1 0", seen, tx); end
    rst = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1 || busy !== 1'b0 || bus.req_o !== 1'b0) begin n_fail++; $display("FAIL rstmid got tx=%b busy=%b req=%b want 1 0 0", tx, busy, bus.req_o); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (50) @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_grant_wait();
    test_wrap();
    test_abort_req();
    test_abort_send();
    test_zero();
`ifdef DUMP_CKSUM_EN
    test_cksum();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule
